// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with fill count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, synchronous flush and optional FWFT read.
module sync_fifo_thresh #(
  parameter int data_width = 8,
  parameter int FIFO_depth = 16,
  parameter int AF_level   = 12,
  parameter int AE_level   = 4,
  parameter int FWFT       = 0
) (
  input  logic                          CLK,
  input  logic                          RST_n,
  input  logic                          clr,
  input  logic [data_width-1:0]         data_in,
  input  logic                          wr_en,
  input  logic                          rd_en,
  output logic [data_width-1:0]         data_out,
  output logic                          valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_depth):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_depth);
  localparam int CW = AW + 1;

  // Handshake: a write is taken when wr_en && !full, a read when rd_en && !empty,
  // both judged on the count before the edge; clr overrides both.
  logic [data_width-1:0] mem [FIFO_depth];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [data_width-1:0] rd_data;
  logic                  rd_vld;
  logic [data_width-1:0] head;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full         = (count == CW'(FIFO_depth));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_level));
  assign almost_empty = (count <= CW'(AE_level));

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (wr_ok && !clr) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_data   <= '0;
      rd_vld    <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_vld    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= head;
      end
      rd_vld <= rd_ok;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  // Memory has no reset, so the FWFT head is masked to zero while empty.
  assign data_out = (FWFT != 0) ? (empty ? '0 : head) : rd_data;
  assign valid    = (FWFT != 0) ? !empty : rd_vld;

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Bench for sync_fifo_thresh: a queue model with a read-data scoreboard for the
// standard-mode instance, a vector table, and hand sequences for FWFT and reset.
module tb_sync_fifo_thresh;

  logic       CLK;
  logic       RST_n;
  logic       clr;
  logic [7:0] data_in;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_out;
  logic       valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  logic       f_clr;
  logic [7:0] f_din;
  logic       f_wr;
  logic       f_rd;
  logic [7:0] f_dout;
  logic       f_valid;
  logic       f_full;
  logic       f_empty;
  logic       f_af;
  logic       f_ae;
  logic [4:0] f_count;
  logic       f_ovf;
  logic       f_udf;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl_q[$];
  logic [7:0] exp_q[$];
  logic       m_ovf;
  logic       m_udf;
  logic       m_vld;
  logic [7:0] m_last;

  typedef struct {
    logic       w;
    logic       r;
    logic       c;
    logic [7:0] d;
    logic [4:0] cnt;
    logic       em;
    logic       udf;
    logic       vld;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[9];

  sync_fifo_thresh #(
    .data_width(8), .FIFO_depth(16), .AF_level(12), .AE_level(4), .FWFT(0)
  ) u_std (
    .CLK(CLK), .RST_n(RST_n), .clr(clr), .data_in(data_in),
    .wr_en(wr_en), .rd_en(rd_en), .data_out(data_out), .valid(valid),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  sync_fifo_thresh #(
    .data_width(8), .FIFO_depth(16), .AF_level(12), .AE_level(4), .FWFT(1)
  ) u_fwft (
    .CLK(CLK), .RST_n(RST_n), .clr(f_clr), .data_in(f_din),
    .wr_en(f_wr), .rd_en(f_rd), .data_out(f_dout), .valid(f_valid),
    .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf),
    .underflow(f_udf)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_q.delete();
    exp_q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_vld  = 1'b0;
    m_last = 8'h00;
  endtask

  // scoreboard + status check against the queue model
  task automatic check_outputs();
    int sz;
    logic [7:0] e;
    sz = mdl_q.size();
    chk("count", 32'(count), 32'(sz));
    chk("full", 32'(full), 32'(sz == 16));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("almost_full", 32'(almost_full), 32'(sz >= 12));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= 4));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    chk("valid", 32'(valid), 32'(m_vld));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_last = e;
    end
    chk("data_out", 32'(data_out), 32'(m_last));
  endtask

  // driver: one clock of stimulus on the standard instance
  task automatic cycle(input logic w, input logic r, input logic [7:0] d, input logic c);
    int   sz;
    logic fm;
    logic em;
    sz = mdl_q.size();
    fm = (sz == 16);
    em = (sz == 0);
    m_vld = 1'b0;
    if (c) begin
      mdl_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (w && fm) m_ovf = 1'b1;
      if (r && em) m_udf = 1'b1;
      if (r && !em) begin
        exp_q.push_back(mdl_q.pop_front());
        m_vld = 1'b1;
      end
      if (w && !fm) mdl_q.push_back(d);
    end
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    clr     = c;
    @(posedge CLK);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
    check_outputs();
  endtask

  task automatic check_fwft_reset(input string tag);
    chk({tag, "_f_count"}, 32'(f_count), 32'd0);
    chk({tag, "_f_empty"}, 32'(f_empty), 32'd1);
    chk({tag, "_f_ae"}, 32'(f_ae), 32'd1);
    chk({tag, "_f_full"}, 32'(f_full), 32'd0);
    chk({tag, "_f_af"}, 32'(f_af), 32'd0);
    chk({tag, "_f_ovf"}, 32'(f_ovf), 32'd0);
    chk({tag, "_f_udf"}, 32'(f_udf), 32'd0);
    chk({tag, "_f_valid"}, 32'(f_valid), 32'd0);
    chk({tag, "_f_dout"}, 32'(f_dout), 32'd0);
  endtask

  initial begin
    vecs[0] = '{w:1, r:0, c:0, d:8'hFA, cnt:5'd1, em:0, udf:0, vld:0, dout:8'h00};
    vecs[1] = '{w:0, r:1, c:0, d:8'h00, cnt:5'd0, em:1, udf:0, vld:1, dout:8'hFA};
    vecs[2] = '{w:0, r:0, c:0, d:8'h00, cnt:5'd0, em:1, udf:0, vld:0, dout:8'hFA};
    vecs[3] = '{w:0, r:1, c:0, d:8'h00, cnt:5'd0, em:1, udf:1, vld:0, dout:8'hFA};
    vecs[4] = '{w:1, r:1, c:0, d:8'h33, cnt:5'd1, em:0, udf:1, vld:0, dout:8'hFA};
    vecs[5] = '{w:0, r:1, c:0, d:8'h00, cnt:5'd0, em:1, udf:1, vld:1, dout:8'h33};
    vecs[6] = '{w:1, r:0, c:1, d:8'h44, cnt:5'd0, em:1, udf:0, vld:0, dout:8'h33};
    vecs[7] = '{w:1, r:0, c:0, d:8'h55, cnt:5'd1, em:0, udf:0, vld:0, dout:8'h33};
    vecs[8] = '{w:0, r:1, c:1, d:8'h00, cnt:5'd0, em:1, udf:0, vld:0, dout:8'h33};

    RST_n = 1'b0; clr = 1'b0; data_in = 8'h00; wr_en = 1'b0; rd_en = 1'b0;
    f_clr = 1'b0; f_din = 8'h00; f_wr = 1'b0; f_rd = 1'b0;
    model_reset();
    #1;
    check_outputs();
    check_fwft_reset("por");
    repeat (2) @(posedge CLK);
    #2 RST_n = 1'b1;
    @(posedge CLK);
    #1;

    // test 1 + boundary vectors from the table
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].w, vecs[i].r, vecs[i].d, vecs[i].c);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].em));
      chk($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].udf));
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].vld));
      chk($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(vecs[i].dout));
    end

    // test 2: overfill then drain
    for (int i = 0; i < 19; i++) begin
      cycle(1'b1, 1'b0, 8'(10 + i), 1'b0);
      if (i == 15) chk("t2_full_at_16", 32'(full), 32'd1);
    end
    chk("t2_count", 32'(count), 32'd16);
    chk("t2_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      chk($sformatf("t2_rd%0d", i), 32'(data_out), 32'(10 + i));
    end
    chk("t2_empty", 32'(empty), 32'd1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // test 3: threshold sweep up and down
    for (int i = 1; i <= 13; i++) begin
      cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
      chk($sformatf("t3_af_up%0d", i), 32'(almost_full), 32'(i >= 12));
      chk($sformatf("t3_ae_up%0d", i), 32'(almost_empty), 32'(i <= 4));
    end
    for (int i = 12; i >= 0; i--) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      chk($sformatf("t3_af_dn%0d", i), 32'(almost_full), 32'(i >= 12));
      chk($sformatf("t3_ae_dn%0d", i), 32'(almost_empty), 32'(i <= 4));
    end

    // test 4a: read+write while full
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
    cycle(1'b1, 1'b1, 8'hAA, 1'b0);
    chk("t4_full_count", 32'(count), 32'd15);
    chk("t4_full_ovf", 32'(overflow), 32'd1);
    chk("t4_full_data", 32'(data_out), 32'h80);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // test 4b: steady state at count 8 across pointer wrap
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b1, 8'(8 + i), 1'b0);
      chk($sformatf("t4_wrap%0d", i), 32'(data_out), 32'(i));
    end
    chk("t4_steady_count", 32'(count), 32'd8);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // test 5: clr at count 10 with overflow set and a write presented
    for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t5_pre_count", 32'(count), 32'd10);
    chk("t5_pre_ovf", 32'(overflow), 32'd1);
    cycle(1'b1, 1'b0, 8'hEE, 1'b1);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_ovf", 32'(overflow), 32'd0);
    cycle(1'b1, 1'b0, 8'h77, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t5_next_word", 32'(data_out), 32'h77);

    // test 6: FWFT instance
    f_wr = 1'b1; f_din = 8'h5A;
    @(posedge CLK); #1;
    f_wr = 1'b0;
    chk("t6_fwft_data", 32'(f_dout), 32'h5A);
    chk("t6_fwft_valid", 32'(f_valid), 32'd1);
    @(posedge CLK); #1;
    chk("t6_fwft_hold", 32'(f_dout), 32'h5A);
    f_rd = 1'b1;
    @(posedge CLK); #1;
    f_rd = 1'b0;
    chk("t6_fwft_empty", 32'(f_empty), 32'd1);
    chk("t6_fwft_valid_low", 32'(f_valid), 32'd0);

    // mid-burst asynchronous reset, with the standard instance holding data
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    f_wr = 1'b1; f_din = 8'h10; wr_en = 1'b1; data_in = 8'hD0;
    @(posedge CLK); #1;
    chk("t6_burst_head", 32'(f_dout), 32'h10);
    f_din = 8'h11;
    @(posedge CLK); #1;
    chk("t6_burst_count", 32'(f_count), 32'd2);
    chk("t6_burst_head2", 32'(f_dout), 32'h10);
    #2 RST_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_fwft_reset("arst");
    f_wr = 1'b0; wr_en = 1'b0;
    @(posedge CLK); #2;
    RST_n = 1'b1;
    @(posedge CLK); #1;
    check_outputs();
    check_fwft_reset("post");
    cycle(1'b1, 1'b0, 8'h99, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    chk("post_reset_word", 32'(data_out), 32'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_thresh.md
# sync_fifo_thresh

Single-clock, parametrised FIFO with a fill counter, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It has a synchronous flush and a selectable first-word-fall-through (FWFT) read mode. It is the same-clock-domain counterpart to the team's asynchronous FIFO and buffers producer/consumer bursts inside one clock domain.

## Interface
- data_width, 8, word width in bits
- FIFO_depth, 16, number of entries; power of two, ≥ 4
- AF_level, 12, almost_full asserts when count ≥ AF_level; legal range 1..FIFO_depth-1
- AE_level, 4, almost_empty asserts when count ≤ AE_level; legal range 0..AF_level-1
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through

- CLK  in  1  single clock, rising edge
- RST_n  in  1  asynchronous reset, active-low
- clr  in  1  synchronous flush
- data_in  in  data_width  write data
- wr_en  in  1  write request
- rd_en  in  1  read request (FWFT: pop the head)
- data_out  out  data_width  read data
- valid  out  1  data_out qualifier
- full  out  1  count == FIFO_depth
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_level
- almost_empty  out  1  count ≤ AE_level
- count  out  $clog2(FIFO_depth)+1  number of stored words
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

## Operation
- **Storage:** FIFO_depth × data_width memory, addressed by write and read pointers of $clog2(FIFO_depth) bits. Pointers wrap naturally from FIFO_depth-1 to 0.
- **Write:** accepted iff wr_en && !full. On acceptance, data_in is stored at the write pointer and the write pointer increments.
- **Read:** accepted iff rd_en && !empty. On acceptance, the read pointer increments.
- **Flag basis:** full and empty are evaluated on the pre-edge count. A write while full is dropped even if a read is accepted in the same cycle.
- **count update:** +1 for a write only, -1 for a read only, unchanged for both or neither.
- **Error flags:**
  - wr_en && full sets overflow.
  - rd_en && empty sets underflow.
  - Both stay set until clr or reset.
- **Standard mode (FWFT=0):** on an accepted read, data_out is loaded with the head word at that edge and valid pulses high for exactly one cycle. Otherwise data_out holds its value and valid=0.
- **FWFT mode (FWFT=1):** data_out always shows the head word; valid = !empty. rd_en acknowledges and pops the current head.
- **clr:** has priority over wr_en and rd_en. At the edge it:
  - zeroes both pointers and count;
  - clears overflow and underflow;
  - drops any write or read presented in that cycle;
  - in standard mode, forces valid=0 and holds data_out.
  
  Memory contents are not cleared.
- **Status outputs:** all flags are registered or decoded from the count register only, with no combinational path from wr_en or rd_en.

## Timing
- **Reset values (asserted immediately on RST_n low, independent of CLK):**
  - count=0, empty=1, almost_empty=1
  - full=0, almost_full=0
  - overflow=0, underflow=0
  - valid=0, data_out=0
  - pointers=0
- **Write latency:** a write accepted at edge N updates count and flags after edge N.
  - Standard mode: the word can be requested from cycle N+1; it appears on data_out after the read edge (1-cycle read latency).
  - FWFT mode: a word written into an empty FIFO appears on data_out with valid=1 right after edge N.
- **Throughput:** one write and one read per cycle sustained, including at the pointer wrap.
- **Boundary conditions:**
  - Simultaneous read and write on an empty FIFO: write accepted, read rejected, underflow set, count becomes 1.
  - Simultaneous read and write on a full FIFO: read accepted, write rejected, overflow set, count becomes FIFO_depth-1.
- **Reset deassertion:** RST_n deasserts asynchronously; the block operates from the first rising CLK edge after release.

## Test plan
All scenarios use defaults unless stated (FIFO_depth=16, AF_level=12, AE_level=4).

1. Reset, write 0xFA, then assert rd_en for one cycle. Required: data_out=0xFA with a valid pulse one cycle after the rd_en edge; count 1→0; empty=1; a second rd_en sets underflow=1.
2. Write 19 words, values 10..28, back-to-back. Required: full=1 after the 16th write; words 26..28 dropped; overflow=1; count=16. Then read 16 words. Required: data 10..25 in order, then empty=1.
3. Threshold sweep. Required: almost_full rises exactly when count reaches 12 and falls at 11; almost_empty falls when count reaches 5 and rises at 4.
4. Simultaneous read/write:
   - From full: count becomes 15 and overflow=1.
   - At count=8 over 40 cycles of an incrementing pattern: count stays 8 and the output sequence is exact across the pointer wrap.
5. clr asserted at count=10, with overflow set and wr_en=1 in the same cycle. Required: count=0, empty=1, overflow=0, and the write is not stored.
6. FWFT=1: write 0x5A into an empty FIFO. Required: data_out=0x5A and valid=1 after the write edge with no rd_en; rd_en then pops it and empty=1. Then RST_n low mid-burst. Required: all outputs at reset values immediately.
